// File: rtl/kamikaze_pkg.sv
// kamikaze_pkg
// Shared constants for the kamikaze fetch/decode front end: datapath
// width, halfword width, the RVC quadrant code that marks a full-width
// instruction, and the default reset PC.
package kamikaze_pkg;

  localparam int XLEN = 32;
  localparam int HW_W = 16;

  localparam logic [1:0]      RVC_QUAD_FULL    = 2'b11;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/kamikaze_instr_align_if.sv
// kamikaze_instr_align_if
// Bundles the word stream from instruction memory, the instruction
// stream towards decode and the redirect (flush) request.
//   slave  : used by kamikaze_instr_align (consumes words, produces instructions)
//   master : used by whoever drives words/flushes and consumes instructions
interface kamikaze_instr_align_if;
  import kamikaze_pkg::*;

  logic [XLEN-1:0] word_i;
  logic            word_valid_i;
  logic            word_ready_o;
  logic [XLEN-1:0] instr_o;
  logic            is_compressed_instr_o;
  logic [XLEN-1:0] pc_o;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic            flush_i;
  logic [XLEN-1:0] flush_pc_i;

  modport slave (
    input  word_i, word_valid_i, instr_ready_i, flush_i, flush_pc_i,
    output word_ready_o, instr_o, is_compressed_instr_o, pc_o, instr_valid_o
  );

  modport master (
    output word_i, word_valid_i, instr_ready_i, flush_i, flush_pc_i,
    input  word_ready_o, instr_o, is_compressed_instr_o, pc_o, instr_valid_o
  );

endinterface

// File: rtl/kamikaze_hw_fifo.sv
// kamikaze_hw_fifo
// Circular halfword FIFO that can push 0, 1 or 2 halfwords and pop 0, 1
// or 2 halfwords in the same cycle. Exposes the occupancy and the two
// oldest entries so the aligner can look at a whole instruction at once.
//   clk_i, rst_i    : clock, asynchronous active-low reset
//   clear_i         : drop all contents (takes priority over push/pop)
//   pushCnt_i       : number of halfwords to append (0..2)
//   pushHw0_i/1_i   : halfwords to append, hw0 first
//   popCnt_i        : number of halfwords to remove from the head (0..2)
//   count_o         : current occupancy
//   head0_o/head1_o : oldest and second-oldest entries
module kamikaze_hw_fifo
  import kamikaze_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [1:0]       pushCnt_i,
  input  logic [HW_W-1:0]  pushHw0_i,
  input  logic [HW_W-1:0]  pushHw1_i,
  input  logic [1:0]       popCnt_i,
  output logic [CNT_W-1:0] count_o,
  output logic [HW_W-1:0]  head0_o,
  output logic [HW_W-1:0]  head1_o
);

  logic [HW_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;

  // Storage and pointers. DEPTH is a power of two, so the pointers wrap
  // naturally; the caller guarantees there is room for every push and
  // enough data for every pop, so no full/empty guarding is done here.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushCnt_i != 2'd0) begin
        mem_q[wrPtr_q] <= pushHw0_i;
      end
      if (pushCnt_i == 2'd2) begin
        mem_q[wrPtr_q + PTR_W'(1)] <= pushHw1_i;
      end
      wrPtr_q <= wrPtr_q + PTR_W'(pushCnt_i);
      rdPtr_q <= rdPtr_q + PTR_W'(popCnt_i);
      count_q <= count_q + CNT_W'(pushCnt_i) - CNT_W'(popCnt_i);
    end
  end

  assign count_o = count_q;
  assign head0_o = mem_q[rdPtr_q];
  assign head1_o = mem_q[rdPtr_q + PTR_W'(1)];

endmodule

// File: rtl/kamikaze_instr_align.sv
// kamikaze_instr_align
// Realigns the 32-bit instruction-memory word stream into whole RV32IC
// instructions (16- or 32-bit, any halfword alignment) with their PC,
// and handles redirects to halfword-aligned targets.
//   clk_i, rst_i : core clock, asynchronous active-low reset
//   bus (slave)  : word_i/word_valid_i/word_ready_o from memory,
//                  instr_o/is_compressed_instr_o/pc_o/instr_valid_o/
//                  instr_ready_i towards decode, flush_i/flush_pc_i redirect
module kamikaze_instr_align
  import kamikaze_pkg::*;
#(
  parameter int              DEPTH_HW = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  kamikaze_instr_align_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH_HW) + 1;

  logic [CNT_W-1:0] fifoCount;
  logic [HW_W-1:0]  hw0;
  logic [HW_W-1:0]  hw1;
  logic             needTwo;
  logic [CNT_W-1:0] neededCnt;
  logic             instrValid;
  logic             wordReady;
  logic             pushFire;
  logic             popFire;
  logic [1:0]       pushCnt;
  logic [1:0]       popCnt;
  logic [HW_W-1:0]  pushHw0;
  logic [XLEN-1:0]  headPc_q, headPc_d;
  logic             skipLo_q, skipLo_d;

  // Anything whose low two bits are not 11 is a compressed instruction;
  // longer encodings are not supported and simply look like 32-bit ones.
  // Word acceptance only looks at the registered occupancy so that the
  // decode-side ready never reaches word_ready_o combinationally.
  always_comb begin
    needTwo    = (hw0[1:0] == RVC_QUAD_FULL);
    neededCnt  = needTwo ? CNT_W'(2) : CNT_W'(1);
    instrValid = (fifoCount >= neededCnt);
    wordReady  = (fifoCount <= CNT_W'(DEPTH_HW - 2));
    pushFire   = bus.word_valid_i && wordReady && !bus.flush_i;
    popFire    = instrValid && bus.instr_ready_i && !bus.flush_i;
    pushCnt    = pushFire ? (skipLo_q ? 2'd1 : 2'd2) : 2'd0;
    pushHw0    = skipLo_q ? bus.word_i[31:16] : bus.word_i[15:0];
    popCnt     = popFire ? (needTwo ? 2'd2 : 2'd1) : 2'd0;
  end

  kamikaze_hw_fifo #(
    .DEPTH (DEPTH_HW)
  ) u_hw_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (bus.flush_i),
    .pushCnt_i (pushCnt),
    .pushHw0_i (pushHw0),
    .pushHw1_i (bus.word_i[31:16]),
    .popCnt_i  (popCnt),
    .count_o   (fifoCount),
    .head0_o   (hw0),
    .head1_o   (hw1)
  );

  // A redirect to an odd-halfword target still receives the full aligned
  // word from upstream, so the first low halfword after it must be
  // dropped; skipLo remembers that until the next accepted word.
  always_comb begin
    headPc_d = headPc_q;
    skipLo_d = skipLo_q;
    if (bus.flush_i) begin
      headPc_d = bus.flush_pc_i & ~XLEN'(1);
      skipLo_d = bus.flush_pc_i[1];
    end else begin
      if (popFire) begin
        headPc_d = headPc_q + (needTwo ? XLEN'(4) : XLEN'(2));
      end
      if (pushFire) begin
        skipLo_d = 1'b0;
      end
    end
  end

  // PC of the instruction at the head of the buffer plus the skip flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      headPc_q <= RESET_PC;
      skipLo_q <= 1'b0;
    end else begin
      headPc_q <= headPc_d;
      skipLo_q <= skipLo_d;
    end
  end

  // Instruction fields are forced to zero whenever nothing is valid so
  // decode never sees stale buffer contents.
  assign bus.instr_valid_o         = instrValid;
  assign bus.instr_o               = !instrValid ? '0
                                   : (needTwo ? {hw1, hw0} : {{HW_W{1'b0}}, hw0});
  assign bus.is_compressed_instr_o = instrValid && !needTwo;
  assign bus.pc_o                  = headPc_q;
  assign bus.word_ready_o          = wordReady;

endmodule

// File: doc/kamikaze_instr_align.md
Name: kamikaze_instr_align

Overview:
Instruction realignment buffer between the instruction-memory word stream and kamikaze_decode. It accepts aligned 32-bit fetch words and splits them into 16-bit halfwords. It then presents one whole RV32IC instruction per handshake (16- or 32-bit, any halfword alignment, including 32-bit instructions that straddle a word boundary), together with its PC. It also handles pipeline redirects (flush) to halfword-aligned targets.

Parameters:
DEPTH_HW, 4, halfword buffer capacity; power of two, minimum 4
RESET_PC, 32'h0000_0000, PC of first instruction after reset

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous reset, active-low
word_i  in  32  fetched memory word, little-endian halfwords
word_valid_i  in  1  word_i valid
word_ready_o  out  1  buffer can accept a full word this cycle
instr_o  out  32  instruction; compressed ones zero-extended in [31:16]
is_compressed_instr_o  out  1  instr_o is a 16-bit instruction
pc_o  out  32  PC of instr_o
instr_valid_o  out  1  instr_o/pc_o valid
instr_ready_i  in  1  decode consumes instruction
flush_i  in  1  redirect; discard all buffered and in-flight data
flush_pc_i  in  32  redirect target, bit 0 ignored (halfword aligned)

Behaviour:
- Reset (rst_i low, async): count=0, head ptr=0, head_pc=RESET_PC, skip_lo=0.
  - Outputs during and after reset: instr_valid_o=0, is_compressed_instr_o=0, instr_o=0, pc_o=RESET_PC, word_ready_o=1 once rst_i is released.
- Word push: occurs when word_valid_i && word_ready_o && !flush_i.
  - Appends word_i[15:0] then word_i[31:16].
  - If skip_lo=1, appends only [31:16] and clears skip_lo.
- word_ready_o = (count <= DEPTH_HW-2), evaluated on the registered count. Pops in the same cycle do not raise it (no combinational path from instr_ready_i).
- Head classification: hw0 = halfword at head.
  - hw0[1:0]==2'b11 means a 32-bit instruction needing 2 halfwords; anything else is 16-bit needing 1.
  - 48-bit and longer encodings are not supported and are treated as 32-bit.
- Outputs (combinational from buffer state):
  - instr_valid_o = (count >= needed).
  - instr_o = {hw1,hw0} for 32-bit, {16'h0,hw0} for 16-bit.
  - is_compressed_instr_o = (needed==1). pc_o = head_pc.
  - When instr_valid_o=0, instr_o and is_compressed_instr_o are don't-care; pc_o is still head_pc.
- Pop: occurs when instr_valid_o && instr_ready_i && !flush_i.
  - Removes `needed` halfwords.
  - head_pc += 2 (compressed) or 4, 32-bit wrap-around (pc 32'hFFFF_FFFE + 2 = 0).
- Simultaneous push and pop in one cycle: count_next = count + pushed − popped. The pointer/wrap logic handles all combinations; no overflow is possible given the word_ready_o rule.
- Latency: a word accepted in cycle N can appear on instr_o in cycle N+1. A 32-bit instruction straddling words needs both words pushed.
- Backpressure: outputs hold stable while instr_valid_o && !instr_ready_i.
- Flush (highest priority; overrides push and pop in the same cycle):
  - count=0 and head_pc=flush_pc_i with bit0 forced 0.
  - skip_lo=flush_pc_i[1].
  - instr_valid_o=0 in the following cycle until new words arrive.
  - Upstream must next deliver the word at {flush_pc_i[31:2],2'b00}.
- Flush during reset has no effect. Reset mid-stream discards everything, and the first instruction comes from RESET_PC.
- No internal state machine beyond count/pointer/skip_lo; the upstream fetch owns address generation.

Decomposition:
- kamikaze_pkg holds XLEN=32, HW_W=16, RVC_QUAD_FULL=2'b11, and the default RESET_PC.
- One sub-module: kamikaze_hw_fifo, a circular halfword FIFO with 0/1/2-entry push and pop per cycle, exposing count and the two head entries.
- kamikaze_instr_align keeps the classification, head_pc and skip_lo logic.

Test Plan:
1. Reset, then push 32'h00A0_0513 then 32'h0041_0113 (two 32-bit instructions), instr_ready_i=1 -> instr_o=32'h00A0_0513 pc_o=0, then 32'h0041_0113 pc_o=4; is_compressed_instr_o=0 throughout.
2. Push 32'h4501_4505 (two RVC) -> instr_o=32'h0000_4505 pc=0 then 32'h0000_4501 pc=2, both with is_compressed_instr_o=1.
3. Straddle: push 32'h0513_4505, then 32'h4501_00A0 -> RVC 4505 @0; 32-bit 00A0_0513 @2 only after the second word; RVC 4501 @6.
4. Backpressure: instr_ready_i=0 with 3 words offered -> word_ready_o drops once count>2; no data lost; draining order and PCs match scenario 1/2 sequencing.
5. Flush with flush_pc_i=32'h0000_0102, then push word 32'h4505_FFFF -> low half discarded; first instr_o=32'h0000_4505, pc_o=32'h102.
6. Flush asserted in the same cycle as push and pop -> buffer empty next cycle; head_pc=flush target; the pushed word is not used.
